// File: rtl/apb_timer_arbiter_if.sv
// rtl/apb_timer_arbiter_if.sv - APB3 bus between the requester arbiter and the timer slave
interface apb_timer_arbiter_if #(
   parameter int APB_ADDR_WIDTH = 12
);
   logic [APB_ADDR_WIDTH-1:0] PADDR;
   logic [31:0]               PWDATA;
   logic                      PWRITE;
   logic                      PSEL;
   logic                      PENABLE;
   logic [31:0]               PRDATA;
   logic                      PREADY;
   logic                      PSLVERR;

   modport master (
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_timer_arbiter.sv
// rtl/apb_timer_arbiter.sv - round-robin APB3 master sharing the timer slave; optional PREADY watchdog via APB_ARB_TIMEOUT_EN
module apb_timer_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                              HCLK,
   input  logic                              HRESET,
   input  logic [NUM_REQ-1:0]                req_i,
   input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*32-1:0]             req_wdata_i,
   input  logic [NUM_REQ-1:0]                req_write_i,
   output logic [NUM_REQ-1:0]                ack_o,
   output logic [31:0]                       rdata_o,
   output logic                              err_o,
   output logic                              busy_o,
   apb_timer_arbiter_if.master               apb
);

   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          ptr_q;
   logic [IDX_W-1:0]          winner_q;
   logic [APB_ADDR_WIDTH-1:0] paddr_q;
   logic [31:0]               pwdata_q;
   logic                      pwrite_q;
   logic [31:0]               rdata_q;
   logic                      err_q;
   logic                      psel;
   logic                      penable;
   logic                      pick_valid;
   logic [IDX_W-1:0]          pick_idx;
   logic                      timeout_hit;
   int                        scan_idx;

   assign apb.PADDR   = paddr_q;
   assign apb.PWDATA  = pwdata_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PSEL    = psel;
   assign apb.PENABLE = penable;
   assign rdata_o     = rdata_q;
   assign err_o       = err_q;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_q;

   // The count this cycle would reach the limit: abandon instead of waiting further
   assign timeout_hit = !apb.PREADY && (wait_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

   // Wait-state counter: cleared while in SETUP so it starts at zero on ACCESS entry, saturating
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wait_cnt_q <= '0;
      end else if (state_q == SETUP) begin
         wait_cnt_q <= '0;
      end else if (state_q == ACCESS && !apb.PREADY && wait_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
         wait_cnt_q <= wait_cnt_q + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Round-robin pick: first set request at or above the pointer, wrapping
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      scan_idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = (int'(ptr_q) + i) % NUM_REQ;
         if (!pick_valid && req_i[scan_idx]) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(scan_idx);
         end
      end
   end

   // State register
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and bus/handshake outputs decoded from the current state
   always_comb begin
      state_d = state_q;
      psel    = 1'b0;
      penable = 1'b0;
      ack_o   = '0;
      busy_o  = 1'b1;
      case (state_q)
         IDLE: begin
            busy_o = 1'b0;
            if (pick_valid) state_d = SETUP;
         end
         SETUP: begin
            psel    = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (apb.PREADY || timeout_hit) state_d = RESP;
         end
         RESP: begin
            ack_o   = NUM_REQ'(1) << winner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: latch the winner's payload, capture the response, advance the pointer
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         ptr_q    <= '0;
         winner_q <= '0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  winner_q <= pick_idx;
                  paddr_q  <= req_addr_i[int'(pick_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                  pwdata_q <= req_wdata_i[int'(pick_idx)*32 +: 32];
                  pwrite_q <= req_write_i[pick_idx];
               end
            end
            ACCESS: begin
               if (apb.PREADY) begin
                  rdata_q <= pwrite_q ? 32'd0 : apb.PRDATA;
                  err_q   <= apb.PSLVERR;
               end else if (timeout_hit) begin
                  rdata_q <= 32'hDEAD_BEEF;
                  err_q   <= 1'b1;
               end
            end
            RESP: begin
               ptr_q <= (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_timer_arbiter.sv
// tb/tb_apb_timer_arbiter.sv - directed self-checking bench for apb_timer_arbiter
module tb_apb_timer_arbiter;
   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [2:0]  req_i;
   logic [35:0] req_addr_i;
   logic [95:0] req_wdata_i;
   logic [2:0]  req_write_i;
   logic [2:0]  ack_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;
   int cyc;
   int acks_seen;
   int enable_cycles;

   apb_timer_arbiter_if #(.APB_ADDR_WIDTH(12)) bus ();

   apb_timer_arbiter #(.NUM_REQ(3), .APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(8)) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .req_i       (req_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .req_write_i (req_write_i),
      .ack_o       (ack_o),
      .rdata_o     (rdata_o),
      .err_o       (err_o),
      .busy_o      (busy_o),
      .apb         (bus.master)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic wait_ack(input int max_cycles, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (ack_o == 3'b000 && cycles < max_cycles);
   endtask

   task automatic do_reset();
      HRESET      = 1'b1;
      req_i       = 3'b000;
      req_write_i = 3'b000;
      tick();
      tick();
      HRESET      = 1'b0;
   endtask

   initial begin
      HRESET      = 1'b1;
      req_i       = '0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      req_write_i = '0;
      bus.PRDATA  = '0;
      bus.PREADY  = 1'b1;
      bus.PSLVERR = 1'b0;
      tick();
      tick();

      // reset state
      check("rst_psel",    32'(bus.PSEL),    32'd0);
      check("rst_penable", 32'(bus.PENABLE), 32'd0);
      check("rst_paddr",   32'(bus.PADDR),   32'd0);
      check("rst_pwdata",  bus.PWDATA,       32'd0);
      check("rst_pwrite",  32'(bus.PWRITE),  32'd0);
      check("rst_ack",     32'(ack_o),       32'd0);
      check("rst_rdata",   rdata_o,          32'd0);
      check("rst_err",     32'(err_o),       32'd0);
      check("rst_busy",    32'(busy_o),      32'd0);
      HRESET = 1'b0;

      // single read from requester 1, zero wait states
      bus.PRDATA = 32'h0000_1234;
      req_addr_i[12 +: 12] = 12'h004;
      req_i = 3'b010;
      tick();
      check("rd_setup_psel",    32'(bus.PSEL),    32'd1);
      check("rd_setup_penable", 32'(bus.PENABLE), 32'd0);
      check("rd_setup_paddr",   32'(bus.PADDR),   32'h004);
      check("rd_setup_busy",    32'(busy_o),      32'd1);
      tick();
      check("rd_access_psel",    32'(bus.PSEL),    32'd1);
      check("rd_access_penable", 32'(bus.PENABLE), 32'd1);
      check("rd_access_ack",     32'(ack_o),       32'd0);
      tick();
      check("rd_ack",   32'(ack_o),    32'b010);
      check("rd_rdata", rdata_o,       32'h0000_1234);
      check("rd_err",   32'(err_o),    32'd0);
      check("rd_psel",  32'(bus.PSEL), 32'd0);
      req_i = 3'b000;
      bus.PRDATA = 32'h0BAD_0BAD;
      tick();
      check("rd_idle_ack",  32'(ack_o),  32'd0);
      check("rd_idle_busy", 32'(busy_o), 32'd0);
      check("rd_hold",      rdata_o,     32'h0000_1234);

      // three simultaneous writes from reset release rotate 0,1,2
      do_reset();
      for (int k = 0; k < 3; k++) begin
         req_addr_i[k*12 +: 12]  = 12'(12'h010 + 4*k);
         req_wdata_i[k*32 +: 32] = 32'h0000_00A0 + 32'(k);
      end
      req_write_i = 3'b111;
      req_i       = 3'b111;
      for (int k = 0; k < 3; k++) begin
         wait_ack(12, cyc);
         check("wr_ack",    32'(ack_o),      32'(3'b001 << k));
         check("wr_gap",    32'(cyc),        (k == 0) ? 32'd3 : 32'd4);
         check("wr_pwdata", bus.PWDATA,      32'h0000_00A0 + 32'(k));
         check("wr_paddr",  32'(bus.PADDR),  32'h010 + 32'(4*k));
         check("wr_pwrite", 32'(bus.PWRITE), 32'd1);
         check("wr_rdata",  rdata_o,         32'd0);
         req_i[k] = 1'b0;
      end
      req_write_i = 3'b000;
      tick();

      // read from requester 0 with five wait states and a slave error
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'h5555_AAAA;
      req_addr_i[0 +: 12] = 12'h020;
      req_i = 3'b001;
      enable_cycles = 0;
      tick();
      check("ws_setup_psel", 32'(bus.PSEL), 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.PENABLE) enable_cycles++;
         check("ws_paddr", 32'(bus.PADDR), 32'h020);
         check("ws_ack",   32'(ack_o),     32'd0);
      end
      tick();
      if (bus.PENABLE) enable_cycles++;
      check("ws_paddr_last", 32'(bus.PADDR), 32'h020);
      bus.PREADY  = 1'b1;
      bus.PSLVERR = 1'b1;
      tick();
      check("ws_access_len", 32'(enable_cycles), 32'd6);
      check("ws_ack",        32'(ack_o),         32'b001);
      check("ws_err",        32'(err_o),         32'd1);
      check("ws_rdata",      rdata_o,            32'h5555_AAAA);
      check("ws_paddr_kept", 32'(bus.PADDR),     32'h020);
      req_i = 3'b000;
      bus.PSLVERR = 1'b0;
      tick();

      // reset during the second ACCESS cycle aborts the transfer
      bus.PREADY = 1'b0;
      req_i = 3'b010;
      tick();
      tick();
      tick();
      check("ab_in_access", 32'(bus.PENABLE), 32'd1);
      HRESET = 1'b1;
      tick();
      check("ab_psel",    32'(bus.PSEL),    32'd0);
      check("ab_penable", 32'(bus.PENABLE), 32'd0);
      check("ab_ack",     32'(ack_o),       32'd0);
      check("ab_busy",    32'(busy_o),      32'd0);
      HRESET = 1'b0;
      bus.PREADY = 1'b1;
      req_i = 3'b011;
      wait_ack(12, cyc);
      check("ab_first", 32'(ack_o), 32'b001);
      req_i[0] = 1'b0;
      wait_ack(12, cyc);
      check("ab_second", 32'(ack_o), 32'b010);
      req_i[1] = 1'b0;

      // pointer wraps after requester 2
      req_i = 3'b100;
      wait_ack(12, cyc);
      check("wrap_r2", 32'(ack_o), 32'b100);
      req_i = 3'b000;
      tick();
      req_i = 3'b101;
      wait_ack(12, cyc);
      check("wrap_r0", 32'(ack_o), 32'b001);
      req_i[0] = 1'b0;
      wait_ack(12, cyc);
      check("wrap_r2_again", 32'(ack_o), 32'b100);
      req_i = 3'b000;
      tick();

      // PREADY stuck low
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'h1111_2222;
      req_i = 3'b001;
`ifdef APB_ARB_TIMEOUT_EN
      wait_ack(40, cyc);
      check("to_ack",   32'(ack_o), 32'b001);
      check("to_lat",   32'(cyc),   32'd10);
      check("to_err",   32'(err_o), 32'd1);
      check("to_rdata", rdata_o,    32'hDEAD_BEEF);
      req_i = 3'b000;
`else
      acks_seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (ack_o != 3'b000) acks_seen++;
      end
      check("stuck_no_ack", 32'(acks_seen),   32'd0);
      check("stuck_busy",   32'(busy_o),      32'd1);
      check("stuck_penable", 32'(bus.PENABLE), 32'd1);
      do_reset();
`endif
      bus.PREADY = 1'b1;
      tick();
      check("final_idle", 32'(busy_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
